// File: rtl/axi4_wr_arbiter_pkg.sv
// Shared AXI4 write-path widths and arbiter FSM state encoding.
package axi_parameters;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ID_W       = 9;
  localparam int unsigned BEAT_W     = 4;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned BURST_W    = 2;
  localparam int unsigned RESP_W     = 2;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_e;

endpackage

// File: rtl/axi4_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant_i, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_M = 2,
  localparam int unsigned GW    = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [GW-1:0]    last_grant_i,
  output logic [GW-1:0]    grant_idx_o,
  output logic             valid_o
);

  logic [GW-1:0] idx;

  always_comb begin
    grant_idx_o = '0;
    valid_o     = 1'b0;
    idx         = '0;
    for (int unsigned i = 1; i <= NUM_M; i++) begin
      idx = GW'((32'(last_grant_i) + i) % NUM_M);
      if (!valid_o && req_i[idx]) begin
        valid_o     = 1'b1;
        grant_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write slave (AW/W/B) among NUM_M masters,
// one transaction in flight; the beat counter, not the master, defines WLAST.
module axi4_wr_arbiter
  import axi_parameters::*;
#(
  parameter  int unsigned NUM_M      = 2,
  parameter  int unsigned ADDR_WIDTH = axi_parameters::ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH = axi_parameters::DATA_WIDTH,
  localparam int unsigned GW         = $clog2(NUM_M),
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_M-1:0][ID_W-1:0]            m_awid,
  input  logic [NUM_M-1:0][ADDR_WIDTH-1:0]      m_awaddr,
  input  logic [NUM_M-1:0][BEAT_W-1:0]          m_awlen,
  input  logic [NUM_M-1:0][SIZE_W-1:0]          m_awsize,
  input  logic [NUM_M-1:0][BURST_W-1:0]         m_awburst,
  input  logic [NUM_M-1:0]                      m_awvalid,
  output logic [NUM_M-1:0]                      m_awready,
  input  logic [NUM_M-1:0][ID_W-1:0]            m_wid,
  input  logic [NUM_M-1:0][DATA_WIDTH-1:0]      m_wdata,
  input  logic [NUM_M-1:0][STRB_WIDTH-1:0]      m_wstrb,
  input  logic [NUM_M-1:0]                      m_wlast,
  input  logic [NUM_M-1:0]                      m_wvalid,
  output logic [NUM_M-1:0]                      m_wready,
  output logic [ID_W-1:0]                       m_bid,
  output logic [RESP_W-1:0]                     m_bresp,
  output logic [NUM_M-1:0]                      m_bvalid,
  input  logic [NUM_M-1:0]                      m_bready,
  output logic [ID_W-1:0]                       s_awid,
  output logic [ADDR_WIDTH-1:0]                 s_awaddr,
  output logic [BEAT_W-1:0]                     s_awlen,
  output logic [SIZE_W-1:0]                     s_awsize,
  output logic [BURST_W-1:0]                    s_awburst,
  output logic                                  s_awvalid,
  input  logic                                  s_awready,
  output logic [ID_W-1:0]                       s_wid,
  output logic [DATA_WIDTH-1:0]                 s_wdata,
  output logic [STRB_WIDTH-1:0]                 s_wstrb,
  output logic                                  s_wlast,
  output logic                                  s_wvalid,
  input  logic                                  s_wready,
  input  logic [ID_W-1:0]                       s_bid,
  input  logic [RESP_W-1:0]                     s_bresp,
  input  logic                                  s_bvalid,
  output logic                                  s_bready,
  output logic [GW-1:0]                         grant,
  output logic                                  busy,
  output logic                                  wlast_err
);

  state_e            state_q;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     last_grant_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic              wlast_err_q;
  logic [GW-1:0]     arb_idx;
  logic              arb_valid;

  rr_arbiter #(.NUM_M(NUM_M)) u_rr (
    .req_i        (m_awvalid),
    .last_grant_i (last_grant_q),
    .grant_idx_o  (arb_idx),
    .valid_o      (arb_valid)
  );

  // Payload fields always follow the owner; only the handshakes are state-gated.
  assign s_awid    = m_awid[grant_q];
  assign s_awaddr  = m_awaddr[grant_q];
  assign s_awlen   = m_awlen[grant_q];
  assign s_awsize  = m_awsize[grant_q];
  assign s_awburst = m_awburst[grant_q];
  assign s_wid     = m_wid[grant_q];
  assign s_wdata   = m_wdata[grant_q];
  assign s_wstrb   = m_wstrb[grant_q];
  assign m_bid     = s_bid;
  assign m_bresp   = s_bresp;
  assign grant     = grant_q;
  assign busy      = !rst && (state_q != IDLE);
  assign wlast_err = wlast_err_q;

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ADDR: begin
          s_awvalid          = m_awvalid[grant_q];
          m_awready[grant_q] = s_awready;
        end
        DATA: begin
          s_wvalid          = m_wvalid[grant_q];
          s_wlast           = (beat_cnt_q == '0);
          m_wready[grant_q] = s_wready;
        end
        RESP: begin
          m_bvalid[grant_q] = s_bvalid;
          s_bready          = m_bready[grant_q];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_M - 1);
      beat_cnt_q   <= '0;
      wlast_err_q  <= 1'b0;
    end else begin
      wlast_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_idx;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (s_awvalid && s_awready) begin
            beat_cnt_q <= m_awlen[grant_q];
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (s_wvalid && s_wready) begin
            wlast_err_q <= (m_wlast[grant_q] != (beat_cnt_q == '0));
            if (beat_cnt_q == '0) begin
              state_q <= RESP;
            end else begin
              beat_cnt_q <= beat_cnt_q - BEAT_W'(1);
            end
          end
        end
        RESP: begin
          if (s_bvalid && s_bready) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed bench for axi4_wr_arbiter with two masters and a scripted slave.
module tb_axi4_wr_arbiter;
  import axi_parameters::*;

  localparam int unsigned NUM_M      = 2;
  localparam int unsigned GW         = $clog2(NUM_M);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                             clk;
  logic                             rst;
  logic [NUM_M-1:0][ID_W-1:0]       m_awid;
  logic [NUM_M-1:0][ADDR_WIDTH-1:0] m_awaddr;
  logic [NUM_M-1:0][BEAT_W-1:0]     m_awlen;
  logic [NUM_M-1:0][SIZE_W-1:0]     m_awsize;
  logic [NUM_M-1:0][BURST_W-1:0]    m_awburst;
  logic [NUM_M-1:0]                 m_awvalid;
  logic [NUM_M-1:0]                 m_awready;
  logic [NUM_M-1:0][ID_W-1:0]       m_wid;
  logic [NUM_M-1:0][DATA_WIDTH-1:0] m_wdata;
  logic [NUM_M-1:0][STRB_WIDTH-1:0] m_wstrb;
  logic [NUM_M-1:0]                 m_wlast;
  logic [NUM_M-1:0]                 m_wvalid;
  logic [NUM_M-1:0]                 m_wready;
  logic [ID_W-1:0]                  m_bid;
  logic [RESP_W-1:0]                m_bresp;
  logic [NUM_M-1:0]                 m_bvalid;
  logic [NUM_M-1:0]                 m_bready;
  logic [ID_W-1:0]                  s_awid;
  logic [ADDR_WIDTH-1:0]            s_awaddr;
  logic [BEAT_W-1:0]                s_awlen;
  logic [SIZE_W-1:0]                s_awsize;
  logic [BURST_W-1:0]               s_awburst;
  logic                             s_awvalid;
  logic                             s_awready;
  logic [ID_W-1:0]                  s_wid;
  logic [DATA_WIDTH-1:0]            s_wdata;
  logic [STRB_WIDTH-1:0]            s_wstrb;
  logic                             s_wlast;
  logic                             s_wvalid;
  logic                             s_wready;
  logic [ID_W-1:0]                  s_bid;
  logic [RESP_W-1:0]                s_bresp;
  logic                             s_bvalid;
  logic                             s_bready;
  logic [GW-1:0]                    grant;
  logic                             busy;
  logic                             wlast_err;

  int n_vec = 0;
  int n_err = 0;

  axi4_wr_arbiter #(.NUM_M(NUM_M)) dut (
    .clk(clk), .rst(rst),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .busy(busy), .wlast_err(wlast_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_M-1:0] onehot(input logic [GW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Entered in ADDR with mi granted; drives the whole burst and B, returns in IDLE.
  // Master asserts its own wlast on every beat index >= wlast_from.
  task automatic run_burst(input logic [GW-1:0] mi, input logic [3:0] len, input int wlast_from);
    logic exp_err;
    exp_err = 1'b0;
    #1;
    chk("grant", 64'(grant), 64'(mi));
    chk("s_awvalid", 64'(s_awvalid), 64'd1);
    chk("s_awlen", 64'(s_awlen), 64'(len));
    chk("m_awready", 64'(m_awready), 64'(onehot(mi)));
    chk("busy_addr", 64'(busy), 64'd1);
    tick();
    m_awvalid[mi] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      m_wvalid[mi] = 1'b1;
      m_wdata[mi]  = DATA_WIDTH'(32'hD000 + b);
      m_wlast[mi]  = (b >= wlast_from);
      #1;
      chk("s_wvalid", 64'(s_wvalid), 64'd1);
      chk("s_wdata", 64'(s_wdata), 64'(32'hD000 + b));
      chk("s_wlast", 64'(s_wlast), 64'(b == int'(len)));
      chk("m_wready", 64'(m_wready), 64'(onehot(mi)));
      chk("wlast_err", 64'(wlast_err), 64'(exp_err));
      exp_err = ((b >= wlast_from) != (b == int'(len)));
      tick();
    end
    m_wvalid[mi] = 1'b0;
    m_wlast[mi]  = 1'b0;
    s_bvalid     = 1'b1;
    s_bresp      = 2'b00;
    s_bid        = ID_W'(9'h40 + 9'(mi));
    m_bready[mi] = 1'b1;
    #1;
    chk("wlast_err_last", 64'(wlast_err), 64'(exp_err));
    chk("m_wready_resp", 64'(m_wready), 64'd0);
    chk("m_bvalid", 64'(m_bvalid), 64'(onehot(mi)));
    chk("s_bready", 64'(s_bready), 64'd1);
    chk("m_bid", 64'(m_bid), 64'(9'h40 + 9'(mi)));
    tick();
    s_bvalid = 1'b0;
    m_bready = '0;
    #1;
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    m_awid    = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_awvalid = '0; m_wid = '0; m_wdata = '0; m_wstrb = '1; m_wlast = '0;
    m_wvalid  = '0; m_bready = '0;
    s_awready = 1'b1; s_wready = 1'b1;
    s_bid     = '0; s_bresp = '0; s_bvalid = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_wlast_err", 64'(wlast_err), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_awvalid", 64'(s_awvalid), 64'd0);
    chk("rst_bvalid", 64'(m_bvalid), 64'd0);

    // 1: M0 len=3 at 0x100
    m_awvalid[0] = 1'b1;
    m_awaddr[0]  = ADDR_WIDTH'(32'h100);
    m_awid[0]    = 9'h011;
    m_awlen[0]   = 4'd3;
    #1;
    chk("t1_awvalid_idle", 64'(s_awvalid), 64'd0);
    tick();
    chk("t1_awaddr", 64'(s_awaddr), 64'h100);
    chk("t1_awid", 64'(s_awid), 64'h011);
    run_burst(1'b0, 4'd3, 3);

    // 2: simultaneous requests rotate 0,1,0,1 after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_awlen   = '0;
    m_awvalid = 2'b11;
    tick();
    for (int k = 0; k < 4; k++) begin
      run_burst(GW'(k % 2), 4'd0, 0);
      if (k < 3) begin
        m_awvalid[k % 2] = 1'b1;
        tick();
      end
    end
    m_awvalid = '0;

    // 3: M1 presents W before AW
    m_wvalid[1] = 1'b1;
    m_wdata[1]  = DATA_WIDTH'(32'hBEEF);
    #1;
    chk("t3_wready_idle", 64'(m_wready), 64'd0);
    chk("t3_swvalid_idle", 64'(s_wvalid), 64'd0);
    tick();
    chk("t3_wready_idle2", 64'(m_wready), 64'd0);
    m_awvalid[1] = 1'b1;
    m_awlen[1]   = 4'd0;
    tick();
    chk("t3_wready_addr", 64'(m_wready), 64'd0);
    run_burst(1'b1, 4'd0, 0);

    // 4: M0 len=2, wlast raised early on beat 2 and held
    m_awvalid[0] = 1'b1;
    m_awlen[0]   = 4'd2;
    tick();
    run_burst(1'b0, 4'd2, 1);

    // 5: B back-pressure from M0 while M1 waits
    m_awvalid[0] = 1'b1;
    m_awlen[0]   = 4'd0;
    tick();
    chk("t5_grant0", 64'(grant), 64'd0);
    m_awvalid[1] = 1'b1;
    m_awlen[1]   = 4'd0;
    tick();
    m_awvalid[0] = 1'b0;
    m_wvalid[0]  = 1'b1;
    m_wlast[0]   = 1'b1;
    tick();
    m_wvalid[0] = 1'b0;
    m_wlast[0]  = 1'b0;
    s_bvalid    = 1'b1;
    s_bid       = 9'h055;
    m_bready    = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t5_sbready", 64'(s_bready), 64'd0);
      chk("t5_bvalid", 64'(m_bvalid), 64'b01);
      chk("t5_grant_hold", 64'(grant), 64'd0);
      chk("t5_awready", 64'(m_awready), 64'd0);
      tick();
    end
    m_bready[0] = 1'b1;
    #1;
    chk("t5_sbready_rel", 64'(s_bready), 64'd1);
    tick();
    s_bvalid = 1'b0;
    m_bready = '0;
    chk("t5_busy_gap", 64'(busy), 64'd0);
    tick();
    run_burst(1'b1, 4'd0, 0);

    // 6: reset during beat 2 of an 8-beat burst
    m_awvalid[0] = 1'b1;
    m_awlen[0]   = 4'd7;
    tick();
    chk("t6_grant0", 64'(grant), 64'd0);
    tick();
    m_awvalid[0] = 1'b0;
    m_wvalid[0]  = 1'b1;
    m_wlast[0]   = 1'b0;
    tick();
    #1;
    chk("t6_beat2", 64'(s_wvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_gate", 64'(s_wvalid), 64'd0);
    tick();
    rst         = 1'b0;
    m_wvalid[0] = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_grant", 64'(grant), 64'd0);
    chk("t6_wready", 64'(m_wready), 64'd0);
    chk("t6_awvalid", 64'(s_awvalid), 64'd0);
    m_awvalid[1] = 1'b1;
    m_awlen[1]   = 4'd1;
    tick();
    run_burst(1'b1, 4'd1, 1);

    // AWLEN=15 boundary
    m_awvalid[0] = 1'b1;
    m_awlen[0]   = 4'd15;
    tick();
    run_burst(1'b0, 4'd15, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
